// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Purpose:
//   Shares one single-port, word-addressed instruction memory between the
//   IF-stage fetch unit (F, read-only) and the program loader / debug port
//   (L, reads and writes). The memory has a registered read: data appears on
//   i_mem_rdata one cycle after the read is issued. The arbiter remembers who
//   issued each read and raises that requester's rvalid on the return cycle.
//
//   Fetch has fixed priority, with two exceptions:
//     - starvation protection: once L has been denied STARVE_LIMIT cycles in a
//       row, L is given the next grant unconditionally (S_STARVE);
//     - lock mode: an L grant with i_l_lock=1 enters S_LOCK, where only L is
//       served until i_l_lock is sampled low.
//
// Handshake (both requesters):
//   A request transfers in the cycle where req and gnt are both high. The
//   requester holds req, addr, we, lock and wdata stable until it sees gnt.
//   Grants are combinational from the registered state and the current
//   requests; at most one grant is high per cycle, and none while i_rst=1.
//
// Ports:
//   i_clk, i_rst             rising-edge clock, synchronous active-high reset
//   i_f_req, i_f_addr        fetch read request / word address
//   o_f_gnt                  fetch request accepted this cycle (comb.)
//   o_f_rvalid, o_f_rdata    fetch read return (cycle after o_f_gnt)
//   i_l_req, i_l_we          loader request, write(1)/read(0)
//   i_l_lock                 loader asks for exclusive ownership
//   i_l_addr, i_l_wdata      loader word address / write data
//   o_l_gnt                  loader request accepted this cycle (comb.)
//   o_l_rvalid, o_l_rdata    loader read return (cycle after a read o_l_gnt)
//   o_mem_en, o_mem_we       memory enable / write enable (comb. from winner)
//   o_mem_addr, o_mem_wdata  memory address / write data
//   i_mem_rdata              registered memory read data
//   o_locked                 arbiter is in S_LOCK
//   o_dbg_state              raw FSM state (0=S_FETCH, 1=S_STARVE, 2=S_LOCK)
// -----------------------------------------------------------------------------
module imem_arbiter #(
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_f_req,
  input  logic [AW-1:0] i_f_addr,
  output logic          o_f_gnt,
  output logic          o_f_rvalid,
  output logic [DW-1:0] o_f_rdata,
  input  logic          i_l_req,
  input  logic          i_l_we,
  input  logic          i_l_lock,
  input  logic [AW-1:0] i_l_addr,
  input  logic [DW-1:0] i_l_wdata,
  output logic          o_l_gnt,
  output logic          o_l_rvalid,
  output logic [DW-1:0] o_l_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_locked,
  output logic [1:0]    o_dbg_state
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_STARVE = 2'd1,
    S_LOCK   = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_starve_cnt;
  logic          r_locked;
  logic          r_rd_pend;     // a read was granted last cycle
  logic          r_rd_owner_l;  // that read belongs to L (else F)

  logic          w_f_gnt;
  logic          w_l_gnt;
  logic          w_rd_gnt;
  logic [CW-1:0] w_cnt_next;

  // ---------------------------------------------------------------------------
  // Grant selection. In S_STARVE and S_LOCK fetch is shut out entirely and
  // any L request is accepted.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_f_gnt = 1'b0;
    w_l_gnt = 1'b0;
    if (!i_rst) begin
      case (r_state)
        S_FETCH: begin
          w_f_gnt = i_f_req;
          w_l_gnt = i_l_req & ~i_f_req;
        end
        S_STARVE, S_LOCK: begin
          w_l_gnt = i_l_req;
        end
        default: begin
          w_f_gnt = 1'b0;
          w_l_gnt = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles where L asked and was
  // refused, saturating at the limit. The FSM looks at the updated value so
  // that L wins in the cycle right after its STARVE_LIMIT-th refusal.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (!i_l_req || w_l_gnt) begin
      w_cnt_next = '0;
    end else if (r_starve_cnt == LIMIT) begin
      w_cnt_next = r_starve_cnt;
    end else begin
      w_cnt_next = r_starve_cnt + CW'(1);
    end
  end

  assign w_rd_gnt = (w_f_gnt | w_l_gnt) & ~(w_l_gnt & i_l_we);

  // ---------------------------------------------------------------------------
  // Memory port: driven straight from the winner.
  // ---------------------------------------------------------------------------
  assign o_mem_en    = w_f_gnt | w_l_gnt;
  assign o_mem_we    = w_l_gnt & i_l_we;
  assign o_mem_addr  = w_l_gnt ? i_l_addr : i_f_addr;
  assign o_mem_wdata = i_l_wdata;

  // ---------------------------------------------------------------------------
  // FSM, starvation counter and read-return bookkeeping.
  // The starve path is taken whether or not L is asking for a lock; a lock
  // request that wins through S_STARVE goes straight on into S_LOCK.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_FETCH;
      r_starve_cnt <= '0;
      r_locked     <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_rd_owner_l <= 1'b0;
    end else begin
      r_starve_cnt <= w_cnt_next;
      r_rd_pend    <= w_rd_gnt;
      r_rd_owner_l <= w_l_gnt;
      case (r_state)
        S_FETCH: begin
          if (w_l_gnt && i_l_lock) begin
            r_state  <= S_LOCK;
            r_locked <= 1'b1;
          end else if (w_cnt_next == LIMIT) begin
            r_state  <= S_STARVE;
            r_locked <= 1'b0;
          end
        end
        S_STARVE: begin
          // One forced L turn, or give up if L withdrew its request.
          if (w_l_gnt && i_l_lock) begin
            r_state  <= S_LOCK;
            r_locked <= 1'b1;
          end else begin
            r_state  <= S_FETCH;
            r_locked <= 1'b0;
          end
        end
        S_LOCK: begin
          // Lock is released by sampling i_l_lock low, independent of i_l_req.
          if (!i_l_lock) begin
            r_state  <= S_FETCH;
            r_locked <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_FETCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. rvalid is also masked by i_rst so a read granted just before a
  // reset never shows up as a return.
  // ---------------------------------------------------------------------------
  assign o_f_gnt     = w_f_gnt;
  assign o_l_gnt     = w_l_gnt;
  assign o_f_rvalid  = r_rd_pend & ~r_rd_owner_l & ~i_rst;
  assign o_l_rvalid  = r_rd_pend &  r_rd_owner_l & ~i_rst;
  assign o_f_rdata   = i_mem_rdata;
  assign o_l_rdata   = i_mem_rdata;
  assign o_locked    = r_locked;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Drives imem_arbiter together with a 32-word registered-read memory model.
// A reference model written as arbitration rules (who is owed a turn, who
// holds the lock, what each memory word contains) predicts grants, memory
// port values and read returns for every cycle; read returns go through an
// expected queue. Directed steps come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int LIM = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          l_req;
  logic          l_we;
  logic          l_lock;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;

  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          locked;
  logic [1:0]    dbg_state;

  imem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_f_req     (f_req),
    .i_f_addr    (f_addr),
    .o_f_gnt     (f_gnt),
    .o_f_rvalid  (f_rvalid),
    .o_f_rdata   (f_rdata),
    .i_l_req     (l_req),
    .i_l_we      (l_we),
    .i_l_lock    (l_lock),
    .i_l_addr    (l_addr),
    .i_l_wdata   (l_wdata),
    .o_l_gnt     (l_gnt),
    .o_l_rvalid  (l_rvalid),
    .o_l_rdata   (l_rdata),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_locked    (locked),
    .o_dbg_state (dbg_state)
  );

  // Single-port memory with registered read.
  logic [DW-1:0] mem [0:31];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ref_mem [0:31];
  logic [DW-1:0] exp_q [$];   // expected read-return data, oldest first
  bit            own_q [$];   // matching owner: 1 = loader, 0 = fetch
  bit            m_lock;      // loader holds exclusive ownership
  bit            m_owed;      // loader is owed an unconditional turn
  int            m_wait;      // consecutive refused loader cycles (capped)
  bit            m_pf, m_pl;  // predicted grants of the last step

  int n_checks = 0;
  int n_errors = 0;
  int reads_granted = 0;
  int rvalid_seen   = 0;
  int obs_wait      = 0;

  // Values observed in the last step.
  logic          g_f_gnt, g_l_gnt, g_f_rvalid, g_l_rvalid, g_mem_we, g_locked;
  logic [DW-1:0] g_f_rdata, g_l_rdata;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already applied; sample at the falling edge,
  // compare against the rules, advance the model, return #1 after the edge.
  task automatic step();
    bit            pf, pl, ef, el, nlock, nowed;
    int            nwait;
    logic [DW-1:0] ed;
    @(negedge clk);

    if (rst) begin
      pf = 1'b0; pl = 1'b0;
    end else if (m_lock || m_owed) begin
      pf = 1'b0; pl = l_req;
    end else begin
      pf = f_req; pl = l_req && !f_req;
    end

    ef = 1'b0; el = 1'b0; ed = '0;
    if (!rst && exp_q.size() > 0) begin
      ed = exp_q[0];
      el = own_q[0];
      ef = !own_q[0];
    end

    g_f_gnt = f_gnt;       g_l_gnt = l_gnt;
    g_f_rvalid = f_rvalid; g_l_rvalid = l_rvalid;
    g_f_rdata = f_rdata;   g_l_rdata = l_rdata;
    g_mem_we = mem_we;     g_locked = locked;

    chk("f_gnt",    DW'(f_gnt),         DW'(pf));
    chk("l_gnt",    DW'(l_gnt),         DW'(pl));
    chk("gnt_excl", DW'(f_gnt & l_gnt), '0);
    chk("mem_en",   DW'(mem_en),        DW'(pf | pl));
    chk("mem_we",   DW'(mem_we),        DW'(pl & l_we));
    if (pf) chk("mem_addr_f", DW'(mem_addr), DW'(f_addr));
    if (pl) chk("mem_addr_l", DW'(mem_addr), DW'(l_addr));
    if (pl && l_we) chk("mem_wdata", mem_wdata, l_wdata);
    chk("f_rvalid", DW'(f_rvalid), DW'(ef));
    chk("l_rvalid", DW'(l_rvalid), DW'(el));
    if (ef) chk("f_rdata", f_rdata, ed);
    if (el) chk("l_rdata", l_rdata, ed);
    chk("locked", DW'(locked), DW'(m_lock));

    if (f_rvalid) rvalid_seen++;
    if (l_rvalid) rvalid_seen++;

    // Loader waiting time outside lock mode, from what the DUT actually did.
    if (rst || !l_req) begin
      obs_wait = 0;
    end else if (l_gnt) begin
      chk("l_wait_bound", DW'(obs_wait <= LIM), DW'(1));
      obs_wait = 0;
    end else if (!locked) begin
      obs_wait++;
    end

    // Scoreboard: retire this cycle's return, then queue new reads.
    if (rst) begin
      exp_q.delete();
      own_q.delete();
    end else if (exp_q.size() > 0) begin
      ed = exp_q.pop_front();
      ef = own_q.pop_front();
    end
    if (pf) begin
      exp_q.push_back(ref_mem[f_addr]); own_q.push_back(1'b0); reads_granted++;
    end
    if (pl && !l_we) begin
      exp_q.push_back(ref_mem[l_addr]); own_q.push_back(1'b1); reads_granted++;
    end
    if (pl && l_we) ref_mem[l_addr] = l_wdata;

    // Ownership rules for the next cycle.
    if (rst) begin
      nlock = 1'b0; nowed = 1'b0; nwait = 0;
    end else begin
      nwait = (l_req && !pl) ? ((m_wait < LIM) ? m_wait + 1 : LIM) : 0;
      if (m_lock) begin
        nlock = l_lock; nowed = 1'b0;
      end else if (pl && l_lock) begin
        nlock = 1'b1;   nowed = 1'b0;
      end else if (m_owed) begin
        nlock = 1'b0;   nowed = 1'b0;
      end else begin
        nlock = 1'b0;   nowed = (nwait == LIM);
      end
    end
    m_lock = nlock; m_owed = nowed; m_wait = nwait;
    m_pf = pf; m_pl = pl;

    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed steps, then random traffic
  // ---------------------------------------------------------------------------
  initial begin
    int  gc;
    int  f_in_lock;
    bit  done;

    rst = 1'b1; f_addr = '0; l_addr = '0; l_wdata = '0;
    idle();
    m_lock = 1'b0; m_owed = 1'b0; m_wait = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    @(posedge clk); #1;

    // Reset state.
    step();
    chk("reset_locked", DW'(g_locked), '0);
    chk("reset_f_gnt",  DW'(g_f_gnt),  '0);
    rst = 1'b0;

    // Program load: fill all 32 words through the loader port.
    for (int a = 0; a < 32; a++) begin
      l_req = 1'b1; l_we = 1'b1; l_addr = AW'(a); l_wdata = $urandom;
      step();
    end
    idle();
    rst = 1'b1; step(); rst = 1'b0;

    // 1: back-to-back fetch reads of 0..3.
    for (int a = 0; a < 4; a++) begin
      f_req = 1'b1; f_addr = AW'(a);
      step();
      chk("t1_f_gnt", DW'(g_f_gnt), DW'(1));
      chk("t1_l_rvalid", DW'(g_l_rvalid), '0);
      if (a > 0) chk("t1_f_rdata", g_f_rdata, ref_mem[a-1]);
    end
    idle(); step();
    chk("t1_f_rdata_last", g_f_rdata, ref_mem[3]);

    // 2: loader read of addr 7 against continuous fetch.
    f_req = 1'b1; f_addr = '0;
    l_req = 1'b1; l_we = 1'b0; l_addr = AW'(7);
    gc = 0; done = 1'b0;
    for (int c = 1; c <= 10 && !done; c++) begin
      step();
      if (g_l_gnt) begin done = 1'b1; gc = c; end
      if (g_f_gnt) f_addr = f_addr + AW'(1);
    end
    chk("t2_l_gnt_cycle", DW'(gc), DW'(LIM + 1));
    l_req = 1'b0;
    step();
    chk("t2_l_rvalid", DW'(g_l_rvalid), DW'(1));
    chk("t2_l_rdata", g_l_rdata, ref_mem[7]);
    chk("t2_fetch_resume", DW'(g_f_gnt), DW'(1));

    // 3: locked write burst to addr 2..5 while fetch keeps asking for addr 2.
    f_req = 1'b1; f_addr = AW'(2);
    l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1; l_addr = AW'(2); l_wdata = 32'hDEADBEEF;
    done = 1'b0; f_in_lock = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (g_f_gnt && g_locked) f_in_lock++;
      if (g_l_gnt) begin
        if (l_addr == AW'(5)) done = 1'b1;
        else l_addr = l_addr + AW'(1);
      end
    end
    chk("t3_burst_done", DW'(done), DW'(1));
    chk("t3_f_gnt_in_lock", DW'(f_in_lock), '0);
    l_req = 1'b0; l_lock = 1'b0;
    step();
    chk("t3_still_locked", DW'(g_locked), DW'(1));
    chk("t3_f_blocked", DW'(g_f_gnt), '0);
    step();
    chk("t3_f_gnt_after", DW'(g_f_gnt), DW'(1));
    chk("t3_unlocked", DW'(g_locked), '0);
    f_req = 1'b0;
    step();
    chk("t3_f_rdata", g_f_rdata, 32'hDEADBEEF);

    // 4: loader write with fetch idle.
    l_req = 1'b1; l_we = 1'b1; l_lock = 1'b0; l_addr = AW'(9); l_wdata = $urandom;
    step();
    chk("t4_mem_we", DW'(g_mem_we), DW'(1));
    chk("t4_l_gnt", DW'(g_l_gnt), DW'(1));
    idle();
    step();
    chk("t4_no_rvalid", DW'(g_l_rvalid), '0);

    // 5a: reset right after a fetch grant discards the return.
    f_req = 1'b1; f_addr = AW'(1);
    step();
    f_req = 1'b0; rst = 1'b1;
    step();
    chk("t5_rvalid_in_rst", DW'(g_f_rvalid), '0);
    rst = 1'b0;
    step();
    chk("t5_rvalid_after_rst", DW'(g_f_rvalid), '0);

    // 5b: reset while locked.
    l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1; l_addr = AW'(10); l_wdata = $urandom;
    step();
    l_req = 1'b0;
    step();
    chk("t5_locked", DW'(g_locked), DW'(1));
    rst = 1'b1;
    step();
    rst = 1'b0; l_lock = 1'b0; f_req = 1'b1; f_addr = AW'(3);
    step();
    chk("t5_f_gnt_after_rst", DW'(g_f_gnt), DW'(1));
    chk("t5_unlocked_after_rst", DW'(g_locked), '0);
    idle();
    step();

    // 6: random traffic, requests held until granted.
    reads_granted = 0;
    rvalid_seen   = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!(f_req && !m_pf)) begin
        f_req  = ($urandom_range(0, 99) < 70);
        f_addr = AW'($urandom_range(0, 31));
      end
      if (!(l_req && !m_pl)) begin
        l_req   = ($urandom_range(0, 99) < 40);
        l_we    = 1'($urandom_range(0, 1));
        l_lock  = ($urandom_range(0, 99) < 25);
        l_addr  = AW'($urandom_range(0, 31));
        l_wdata = $urandom;
      end
      step();
    end
    idle();
    step();
    chk("rand_read_returns", DW'(rvalid_seen), DW'(reads_granted));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
